// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings and the DIVU sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_DIVU = 4'b0100;
  localparam logic [3:0] ALU_BNE  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } divu_state_e;

endpackage

// File: rtl/divu_step.sv
// One restoring shift-subtract iteration: produces one quotient bit.
module divu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Compare on WIDTH+1 bits; when it succeeds the difference always fits in WIDTH bits.
  assign shifted = {rem, q[WIDTH-1]};
  assign diff    = shifted[WIDTH-1:0] - divisor;

  always_comb begin
    rem_next = shifted[WIDTH-1:0];
    q_next   = {q[WIDTH-2:0], 1'b0};
    if (shifted >= {1'b0, divisor}) begin
      rem_next = diff;
      q_next   = {q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/divu_sequencer.sv
// Multi-cycle unsigned divide controller beside the EX-stage ALU; remainder to hi, quotient to lo.
// Optional DIVU_EARLY_ZERO_EN: a zero divisor skips the iterations and completes in one cycle.
module divu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter logic [3:0]  OP_DIVU = ALU_DIVU
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

  divu_state_e      state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic             accept;

  assign accept = op_valid && (alu_op == OP_DIVU) && !flush;

  divu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem),
    .q        (quo),
    .divisor  (dvsr),
    .rem_next (rem_next),
    .q_next   (quo_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StIdle;
      count <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          busy <= 1'b0;
          if (accept) begin
            rem   <= '0;
            quo   <= dividend;
            dvsr  <= divisor;
            count <= '0;
            state <= StRun;
            busy  <= 1'b1;
`ifdef DIVU_EARLY_ZERO_EN
            // Later assignments override the normal start.
            if (divisor == '0) begin
              state <= StDone;
              busy  <= 1'b0;
              done  <= 1'b1;
              hi    <= dividend;
              lo    <= '1;
            end
`endif
          end
        end
        StRun: begin
          if (flush) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + 1'b1;
            if (count == LastIter) begin
              state <= StDone;
              busy  <= 1'b0;
              done  <= 1'b1;
              hi    <= rem_next;
              lo    <= quo_next;
            end
          end
        end
        StDone: begin
          // Result already committed; flush here has no effect.
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
